// File: rtl/seg_scan_driver.sv
// Two-digit multiplexed seven-segment driver with anode dead time between slots.
// Optional SEG_LEADING_ZERO_BLANK_EN: blank the left digit when its nibble is zero.
module seg_scan_driver #(
    parameter int REFRESH_DIV = 100000,
    parameter int DEAD_CYC    = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] data_in,
    input  logic       load,
    output logic [6:0] seg_cat,
    output logic [1:0] seg_an
);

    localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(REFRESH_DIV - 1);
    localparam logic [CW-1:0] DEAD     = CW'(DEAD_CYC);

    typedef enum logic {BLANK, SHOW} mode_t;

    mode_t         mode;
    mode_t         mode_next;
    logic [CW-1:0] cnt;
    logic          dig;
    logic [7:0]    data_reg;
    logic [3:0]    nibble;
    logic [1:0]    an_next;
    logic [6:0]    cat_next;

    // Cathode patterns are active-low, ordered {g,f,e,d,c,b,a}.
    function automatic logic [6:0] decode(input logic [3:0] n);
        logic [6:0] c;
        c = 7'b1111111;
        case (n)
            4'h0: c = 7'b1000000;
            4'h1: c = 7'b1111001;
            4'h2: c = 7'b0100100;
            4'h3: c = 7'b0110000;
            4'h4: c = 7'b0011001;
            4'h5: c = 7'b0010010;
            4'h6: c = 7'b0000010;
            4'h7: c = 7'b1111000;
            4'h8: c = 7'b0000000;
            4'h9: c = 7'b0010000;
            4'hA: c = 7'b0001000;
            4'hB: c = 7'b0000011;
            4'hC: c = 7'b1000110;
            4'hD: c = 7'b0100001;
            4'hE: c = 7'b0000110;
            4'hF: c = 7'b0001110;
        endcase
        return c;
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            mode     <= BLANK;
            cnt      <= '0;
            dig      <= 1'b0;
            data_reg <= 8'h00;
        end else begin
            mode <= mode_next;
            if (cnt == CNT_LAST) begin
                cnt <= '0;
                dig <= ~dig;
            end else begin
                cnt <= cnt + 1'b1;
            end
            if (load) begin
                data_reg <= data_in;
            end
        end
    end

    always_comb begin
        mode_next = mode;
        if (load) begin
            mode_next = SHOW;
        end
    end

    // Dead time is measured from slot start only, so a load never reopens it.
    always_comb begin
        an_next  = 2'b11;
        cat_next = 7'b1111111;
        nibble   = dig ? data_reg[7:4] : data_reg[3:0];
        if (mode == SHOW && cnt >= DEAD) begin
            if (dig) begin
`ifdef SEG_LEADING_ZERO_BLANK_EN
                if (nibble != 4'h0) begin
                    an_next  = 2'b01;
                    cat_next = decode(nibble);
                end
`else
                an_next  = 2'b01;
                cat_next = decode(nibble);
`endif
            end else begin
                an_next  = 2'b10;
                cat_next = decode(nibble);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            seg_an  <= 2'b11;
            seg_cat <= 7'b1111111;
        end else begin
            seg_an  <= an_next;
            seg_cat <= cat_next;
        end
    end

endmodule

// File: tb/tb_seg_scan_driver.sv
// Directed bench for seg_scan_driver at REFRESH_DIV=8, DEAD_CYC=2.
// Honours SEG_LEADING_ZERO_BLANK_EN when computing left-digit expectations.
module tb_seg_scan_driver;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] data_in = 8'h00;
    logic       load = 1'b0;
    logic [6:0] seg_cat;
    logic [1:0] seg_an;

    int n_compared   = 0;
    int n_mismatched = 0;

    // Reference state as the spec describes it, advanced once per edge.
    int         m_cnt  = 0;
    bit         m_dig  = 1'b0;
    bit         m_show = 1'b0;
    logic [7:0] m_data = 8'h00;

    seg_scan_driver #(.REFRESH_DIV(8), .DEAD_CYC(2)) dut (
        .clk     (clk),
        .rst     (rst),
        .data_in (data_in),
        .load    (load),
        .seg_cat (seg_cat),
        .seg_an  (seg_an)
    );

    always #5 clk = ~clk;

    function automatic logic [6:0] seg_of(input logic [3:0] n);
        logic [6:0] t [16];
        t = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
              7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
              7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
              7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};
        return t[n];
    endfunction

    function automatic logic [8:0] expect_pins(input int c, input bit d, input bit s,
                                               input logic [7:0] dt);
        if (!s || c < 2) return {2'b11, 7'b1111111};
        if (!d) return {2'b10, seg_of(dt[3:0])};
`ifdef SEG_LEADING_ZERO_BLANK_EN
        if (dt[7:4] == 4'h0) return {2'b11, 7'b1111111};
`endif
        return {2'b01, seg_of(dt[7:4])};
    endfunction

    task automatic checkOutput(input string tag, input logic [1:0] exp_an,
                               input logic [6:0] exp_cat);
        n_compared++;
        assert (seg_an === exp_an) else begin
            n_mismatched++;
            $error("[TB] FAIL %s seg_an observed=%b expected=%b", tag, seg_an, exp_an);
        end
        n_compared++;
        assert (seg_cat === exp_cat) else begin
            n_mismatched++;
            $error("[TB] FAIL %s seg_cat observed=%b expected=%b", tag, seg_cat, exp_cat);
        end
        n_compared++;
        assert (seg_an !== 2'b00) else begin
            n_mismatched++;
            $error("[TB] FAIL %s two_anodes observed=%b expected=not 00", tag, seg_an);
        end
    endtask

    // Drive one edge, then check pins against the state held before that edge.
    task automatic applyStimulus(input logic ld, input logic [7:0] din, input logic r,
                                 input string tag);
        logic [8:0] e;
        load    = ld;
        data_in = din;
        rst     = r;
        @(posedge clk);
        #1;
        e = r ? {2'b11, 7'b1111111} : expect_pins(m_cnt, m_dig, m_show, m_data);
        if (r) begin
            m_cnt  = 0;
            m_dig  = 1'b0;
            m_show = 1'b0;
            m_data = 8'h00;
        end else begin
            if (m_cnt == 7) begin
                m_cnt = 0;
                m_dig = ~m_dig;
            end else begin
                m_cnt++;
            end
            if (ld) begin
                m_data = din;
                m_show = 1'b1;
            end
        end
        checkOutput(tag, e[8:7], e[6:0]);
    endtask

    initial begin
        bit aligned;

        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 8'h00, 1'b1, "reset");
        for (int i = 0; i < 40; i++) applyStimulus(1'b0, 8'h00, 1'b0, "idle_blank");

        applyStimulus(1'b1, 8'h3A, 1'b0, "load_3A");
        for (int i = 0; i < 32; i++) applyStimulus(1'b0, 8'h00, 1'b0, "show_3A");

        applyStimulus(1'b1, 8'h05, 1'b0, "load_05");
        for (int i = 0; i < 24; i++) applyStimulus(1'b0, 8'h00, 1'b0, "show_05");

        // Park on cnt=7 of a right slot so the next edge both wraps and loads.
        aligned = 1'b0;
        for (int i = 0; i < 20 && !aligned; i++) begin
            if (m_cnt == 7 && m_dig == 1'b0) aligned = 1'b1;
            else applyStimulus(1'b0, 8'h00, 1'b0, "align");
        end
        n_compared++;
        assert (aligned) else begin
            n_mismatched++;
            $error("[TB] FAIL align_timeout observed=%0d expected=1", aligned);
        end
        applyStimulus(1'b1, 8'h12, 1'b0, "wrap_load_12");
        applyStimulus(1'b0, 8'h00, 1'b0, "wrap_dead0");
        checkOutput("wrap_dead0_const", 2'b11, 7'b1111111);
        applyStimulus(1'b0, 8'h00, 1'b0, "wrap_dead1");
        applyStimulus(1'b0, 8'h00, 1'b0, "wrap_left");
        checkOutput("wrap_left_const", 2'b01, 7'b1111001);
        for (int i = 0; i < 12; i++) applyStimulus(1'b0, 8'h00, 1'b0, "show_12");

        applyStimulus(1'b1, 8'h11, 1'b0, "hold_11");
        applyStimulus(1'b1, 8'h2C, 1'b0, "hold_2C");
        applyStimulus(1'b1, 8'h3D, 1'b0, "hold_3D");
        applyStimulus(1'b1, 8'h4E, 1'b0, "hold_4E");
        for (int i = 0; i < 18; i++) applyStimulus(1'b0, 8'h99, 1'b0, "persist_4E");

        // Loads landing inside dead windows must not stretch the blank time.
        while (m_cnt != 0) applyStimulus(1'b0, 8'h00, 1'b0, "to_slot_start");
        applyStimulus(1'b1, 8'hB7, 1'b0, "dead_load_B7");
        applyStimulus(1'b1, 8'h86, 1'b0, "dead_load_86");
        for (int i = 0; i < 10; i++) applyStimulus(1'b0, 8'h00, 1'b0, "show_86");

        applyStimulus(1'b1, 8'hFF, 1'b0, "load_FF");
        while (m_cnt != 4) applyStimulus(1'b0, 8'h00, 1'b0, "show_FF");
        applyStimulus(1'b0, 8'h00, 1'b0, "mid_FF");
        applyStimulus(1'b1, 8'hAA, 1'b1, "rst_with_load");
        checkOutput("rst_with_load_const", 2'b11, 7'b1111111);
        for (int i = 0; i < 20; i++) applyStimulus(1'b0, 8'h55, 1'b0, "post_rst_blank");

        applyStimulus(1'b1, 8'h00, 1'b0, "load_00");
        for (int i = 0; i < 18; i++) applyStimulus(1'b0, 8'h00, 1'b0, "show_00");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule

// File: doc/seg_scan_driver.md
SEG_SCAN_DRIVER -- requirements
Module: seg_scan_driver

Interface
REQ-001 Parameter REFRESH_DIV, default 100000, clock cycles per digit slot; legal range 2..2^20.
REQ-002 Parameter DEAD_CYC, default 2, cycles at the start of each slot with both anodes off; legal range 0..REFRESH_DIV-1.
REQ-003 Port clk  input  1  system clock; all state updates on its rising edge.
REQ-004 Port rst  input  1  synchronous, active-high reset.
REQ-005 Port data_in  input  8  byte to display; bits [3:0] right digit, bits [7:4] left digit.
REQ-006 Port load  input  1  capture strobe; data_in sampled on any edge where load=1.
REQ-007 Port seg_cat  output  7  active-low cathodes {g,f,e,d,c,b,a}, registered.
REQ-008 Port seg_an  output  2  active-low anodes; 2'b10 = right digit, 2'b01 = left digit, 2'b11 = both off; registered.

Function
REQ-009 Internal state: data_reg[7:0], prescaler cnt, digit select dig (0 = right, 1 = left), mode FSM {BLANK, SHOW}.
REQ-010 cnt counts 0..REFRESH_DIV-1 and wraps to 0; on the wrap edge dig toggles.
REQ-011 load=1 at edge N: data_reg = data_in after N; FSM goes BLANK->SHOW at N, or stays SHOW.
REQ-012 Outputs are computed from post-edge-N state and registered at edge N+1, giving one cycle of latency from any state change to the pins.
REQ-013 In BLANK: seg_an=2'b11, seg_cat=7'b1111111 regardless of cnt and dig; cnt and dig keep running.
REQ-014 In SHOW with cnt < DEAD_CYC: seg_an=2'b11, seg_cat=7'b1111111 (ghosting guard).
REQ-015 In SHOW with cnt >= DEAD_CYC: dig=0 drives seg_an=2'b10 and nibble data_reg[3:0]; dig=1 drives seg_an=2'b01 and nibble data_reg[7:4].
REQ-016 Nibble-to-cathode table: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000, A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110.
REQ-017 Load on the same edge as a cnt wrap: both take effect, so the new slot shows the new data.
REQ-018 Load held high for several cycles: data_reg tracks data_in every cycle; the last sampled value persists after load falls.
REQ-019 Load during a dead-time window does not extend or restart the window.
REQ-020 Only one anode is ever low at a time; seg_an=2'b00 never occurs.

Reset
REQ-021 rst=1 at an edge: cnt=0, dig=0, data_reg=8'h00, FSM=BLANK, seg_an=2'b11, seg_cat=7'b1111111 after that edge.
REQ-022 rst has priority over load on the same edge; reset mid-slot discards data_reg and blanks the display.
REQ-023 After rst falls, the display stays blank until the first load.

Configuration
REQ-024 Macro SEG_LEADING_ZERO_BLANK_EN defined: in SHOW with dig=1 and data_reg[7:4]=0, seg_an=2'b11 and seg_cat=7'b1111111 for the whole left slot; cnt and dig timing are unchanged.
REQ-025 Macro SEG_LEADING_ZERO_BLANK_EN undefined: the left digit shows "0" (seg_cat=1000000) when the high nibble is zero.

Verification (REFRESH_DIV=8, DEAD_CYC=2)
REQ-026 Reset 3 cycles, no load for 40 cycles -> seg_an=2'b11 and seg_cat=7'b1111111 on every cycle.
REQ-027 Load 8'h3A once -> each 8-cycle slot shows 2 cycles of 2'b11, then 6 cycles of right slot 2'b10/0001000 or left slot 2'b01/0110000, alternating; pins update one cycle after the state change.
REQ-028 Load 8'h05 -> with the macro, left slot is 2'b11 throughout and right slot shows 0010010; without the macro, left slot shows 2'b01/1000000.
REQ-029 Load 8'h12 on the cnt=7 edge -> the next slot (left) shows 1111001 after dead time; there is no stale-data cycle.
REQ-030 Assert rst mid-slot while 8'hFF is displayed -> pins are 2'b11/1111111 after the edge and stay blank until the next load; load with rst both high leaves data_reg at 00.
